// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory arbiter: owner ids, FSM states and the
// round-robin pick used in IDLE.
package mem_arb_pkg;

    typedef logic owner_t;

    localparam owner_t OWN_IC = 1'b0;
    localparam owner_t OWN_DC = 1'b1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] HOLD  = 2'd1;
    localparam logic [1:0] WDATA = 2'd2;

    localparam int MAX_OUTSTANDING_DEF = 4;

    // On a tie the requester that did not win last time gets the grant.
    function automatic owner_t rr_pick(input logic ic_elig, input logic dc_elig,
                                       input owner_t rr_last);
        if (ic_elig && dc_elig) return ~rr_last;
        else if (dc_elig)       return OWN_DC;
        else                    return OWN_IC;
    endfunction

endpackage

// File: rtl/arb_owner_fifo.sv
// Records which cache issued each outstanding read so that in-order memory
// responses can be steered back to it.
module arb_owner_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = MAX_OUTSTANDING_DEF
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  owner_t push_owner,
    input  logic   pop,
    output logic   full,
    output logic   empty,
    output owner_t head
);

    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_owner;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the instruction and
// data caches; read responses are routed back through an owner FIFO.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_BITS       = 28,
    parameter int DATA_BITS       = 128,
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   ic_req_valid,
    output logic                   ic_req_ready,
    input  logic [ADDR_BITS-1:0]   ic_req_addr,
    input  logic                   ic_req_rw,
    input  logic                   ic_req_data_valid,
    output logic                   ic_req_data_ready,
    input  logic [DATA_BITS-1:0]   ic_req_data_bits,
    input  logic [DATA_BITS/8-1:0] ic_req_data_mask,
    output logic                   ic_resp_valid,
    output logic [DATA_BITS-1:0]   ic_resp_data,

    input  logic                   dc_req_valid,
    output logic                   dc_req_ready,
    input  logic [ADDR_BITS-1:0]   dc_req_addr,
    input  logic                   dc_req_rw,
    input  logic                   dc_req_data_valid,
    output logic                   dc_req_data_ready,
    input  logic [DATA_BITS-1:0]   dc_req_data_bits,
    input  logic [DATA_BITS/8-1:0] dc_req_data_mask,
    output logic                   dc_resp_valid,
    output logic [DATA_BITS-1:0]   dc_resp_data,

    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [ADDR_BITS-1:0]   mem_req_addr,
    output logic                   mem_req_rw,
    output logic                   mem_req_data_valid,
    input  logic                   mem_req_data_ready,
    output logic [DATA_BITS-1:0]   mem_req_data_bits,
    output logic [DATA_BITS/8-1:0] mem_req_data_mask,
    input  logic                   mem_resp_valid,
    input  logic [DATA_BITS-1:0]   mem_resp_data,

    output logic                   err
);

    logic [1:0] state;
    owner_t     owner_q;
    owner_t     rr_last;
    logic       data_done;

    logic       fifo_full;
    logic       fifo_empty;
    owner_t     fifo_head;

    logic       ic_elig, dc_elig;
    owner_t     sel, cur_owner;
    logic       active, data_path;
    logic       o_valid, o_rw, o_data_valid;
    logic       cmd_fire, data_fire;

    // A read may only be granted while there is room to remember its owner.
    assign ic_elig = ic_req_valid && (ic_req_rw || !fifo_full);
    assign dc_elig = dc_req_valid && (dc_req_rw || !fifo_full);
    assign sel     = rr_pick(ic_elig, dc_elig, rr_last);

    always_comb begin
        cur_owner    = (state == IDLE) ? sel : owner_q;
        active       = ((state == IDLE) && (ic_elig || dc_elig)) || (state == HOLD);
        data_path    = (active && !data_done) || (state == WDATA);
        o_valid      = (cur_owner == OWN_DC) ? dc_req_valid      : ic_req_valid;
        o_rw         = (cur_owner == OWN_DC) ? dc_req_rw         : ic_req_rw;
        o_data_valid = (cur_owner == OWN_DC) ? dc_req_data_valid : ic_req_data_valid;
        cmd_fire     = active && o_valid && mem_req_ready;
        data_fire    = data_path && o_data_valid && mem_req_data_ready;
    end

    // Handshake outputs are forced low while reset is asserted.
    always_comb begin
        mem_req_addr       = (cur_owner == OWN_DC) ? dc_req_addr      : ic_req_addr;
        mem_req_data_bits  = (cur_owner == OWN_DC) ? dc_req_data_bits : ic_req_data_bits;
        mem_req_data_mask  = (cur_owner == OWN_DC) ? dc_req_data_mask : ic_req_data_mask;
        mem_req_rw         = o_rw;
        mem_req_valid      = reset && active && o_valid;
        mem_req_data_valid = reset && data_path && o_data_valid;
        ic_req_ready       = reset && active && (cur_owner == OWN_IC) && mem_req_ready;
        dc_req_ready       = reset && active && (cur_owner == OWN_DC) && mem_req_ready;
        ic_req_data_ready  = reset && data_path && (cur_owner == OWN_IC) && mem_req_data_ready;
        dc_req_data_ready  = reset && data_path && (cur_owner == OWN_DC) && mem_req_data_ready;
        ic_resp_valid      = reset && mem_resp_valid && !fifo_empty && (fifo_head == OWN_IC);
        dc_resp_valid      = reset && mem_resp_valid && !fifo_empty && (fifo_head == OWN_DC);
        ic_resp_data       = mem_resp_data;
        dc_resp_data       = mem_resp_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            owner_q   <= OWN_IC;
            rr_last   <= OWN_IC;
            data_done <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (mem_resp_valid && fifo_empty)
                err <= 1'b1;
            case (state)
                IDLE, HOLD: begin
                    if (active) begin
                        owner_q <= cur_owner;
                        if (cmd_fire) begin
                            data_done <= 1'b0;
                            if (!o_rw || data_fire || data_done) begin
                                state   <= IDLE;
                                rr_last <= cur_owner;
                            end else begin
                                state <= WDATA;
                            end
                        end else begin
                            state <= HOLD;
                            if (data_fire)
                                data_done <= 1'b1;
                        end
                    end
                end
                WDATA: begin
                    if (data_fire) begin
                        state   <= IDLE;
                        rr_last <= owner_q;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    arb_owner_fifo #(.DEPTH(MAX_OUTSTANDING)) u_owner_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (cmd_fire && !o_rw),
        .push_owner (cur_owner),
        .pop        (mem_resp_valid),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head       (fifo_head)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, round-robin, grant hold, write data
// phase, FIFO-full blocking and the stray-response error flag.
module tb_mem_arbiter;
    localparam int AB = 28;
    localparam int DB = 128;

    logic          clk = 1'b0;
    logic          reset;
    logic          ic_req_valid, ic_req_ready, ic_req_rw, ic_req_data_valid, ic_req_data_ready;
    logic [AB-1:0] ic_req_addr;
    logic [DB-1:0] ic_req_data_bits, ic_resp_data;
    logic [DB/8-1:0] ic_req_data_mask;
    logic          ic_resp_valid;
    logic          dc_req_valid, dc_req_ready, dc_req_rw, dc_req_data_valid, dc_req_data_ready;
    logic [AB-1:0] dc_req_addr;
    logic [DB-1:0] dc_req_data_bits, dc_resp_data;
    logic [DB/8-1:0] dc_req_data_mask;
    logic          dc_resp_valid;
    logic          mem_req_valid, mem_req_ready, mem_req_rw, mem_req_data_valid, mem_req_data_ready;
    logic [AB-1:0] mem_req_addr;
    logic [DB-1:0] mem_req_data_bits, mem_resp_data;
    logic [DB/8-1:0] mem_req_data_mask;
    logic          mem_resp_valid;
    logic          err;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .MAX_OUTSTANDING(4)) dut (
        .clk(clk), .reset(reset),
        .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
        .ic_req_rw(ic_req_rw), .ic_req_data_valid(ic_req_data_valid),
        .ic_req_data_ready(ic_req_data_ready), .ic_req_data_bits(ic_req_data_bits),
        .ic_req_data_mask(ic_req_data_mask), .ic_resp_valid(ic_resp_valid),
        .ic_resp_data(ic_resp_data),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_addr(dc_req_addr),
        .dc_req_rw(dc_req_rw), .dc_req_data_valid(dc_req_data_valid),
        .dc_req_data_ready(dc_req_data_ready), .dc_req_data_bits(dc_req_data_bits),
        .dc_req_data_mask(dc_req_data_mask), .dc_resp_valid(dc_resp_valid),
        .dc_resp_data(dc_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_rw(mem_req_rw),
        .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
        .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .err(err)
    );

    task automatic chk(input string tag, input logic [DB-1:0] got, input logic [DB-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        ic_req_valid = 0; ic_req_rw = 0; ic_req_data_valid = 0; ic_req_addr = '0;
        ic_req_data_bits = '0; ic_req_data_mask = '0;
        dc_req_valid = 0; dc_req_rw = 0; dc_req_data_valid = 0; dc_req_addr = '0;
        dc_req_data_bits = '0; dc_req_data_mask = '0;
        mem_resp_valid = 0; mem_resp_data = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DB-1:0] wd;
        reset = 0;
        clr();
        mem_req_ready = 1; mem_req_data_ready = 1;

        // 1: reset holds every handshake low, dc wins the first tie
        ic_req_valid = 1; dc_req_valid = 1; ic_req_data_valid = 1;
        ic_req_addr = 28'h0000AAA; dc_req_addr = 28'h0000BBB;
        #2;
        chk("rst_ic_ready", 128'(ic_req_ready), 128'(0));
        chk("rst_dc_ready", 128'(dc_req_ready), 128'(0));
        chk("rst_mem_valid", 128'(mem_req_valid), 128'(0));
        chk("rst_mem_dvalid", 128'(mem_req_data_valid), 128'(0));
        chk("rst_ic_dready", 128'(ic_req_data_ready), 128'(0));
        repeat (2) tick();
        chk("rst_hold_dc_ready", 128'(dc_req_ready), 128'(0));
        chk("rst_err", 128'(err), 128'(0));
        ic_req_data_valid = 0;
        reset = 1;
        #1;
        chk("rel_dc_ready", 128'(dc_req_ready), 128'(1));
        chk("rel_ic_ready", 128'(ic_req_ready), 128'(0));
        chk("rel_addr", 128'(mem_req_addr), 128'(28'h0000BBB));
        clr();
        tick();

        // 2: both read each cycle, responses two cycles behind
        for (int c = 0; c < 6; c++) begin
            ic_req_valid = (c < 4); dc_req_valid = (c < 4);
            ic_req_addr = 28'h100 + AB'(c); dc_req_addr = 28'h200 + AB'(c);
            mem_resp_valid = (c >= 2);
            mem_resp_data = {32'hA5A5_0000 + 32'(c), 96'h1234};
            #1;
            chk("rr_dc_ready", 128'(dc_req_ready), 128'((c < 4) && (c % 2 == 0)));
            chk("rr_ic_ready", 128'(ic_req_ready), 128'((c < 4) && (c % 2 == 1)));
            if (c < 4)
                chk("rr_addr", 128'(mem_req_addr),
                    128'((c % 2 == 0) ? 28'h200 + AB'(c) : 28'h100 + AB'(c)));
            chk("rr_dc_resp", 128'(dc_resp_valid), 128'((c >= 2) && (c % 2 == 0)));
            chk("rr_ic_resp", 128'(ic_resp_valid), 128'((c >= 2) && (c % 2 == 1)));
            if (c >= 2) begin
                wd = {32'hA5A5_0000 + 32'(c), 96'h1234};
                chk("rr_dc_rdata", dc_resp_data, wd);
                chk("rr_ic_rdata", ic_resp_data, wd);
            end
            tick();
        end
        clr();

        // 3: ic grant held while memory stalls; dc locked out
        ic_req_valid = 1; ic_req_addr = 28'h0000010; mem_req_ready = 0;
        #1;
        chk("hold_c0_valid", 128'(mem_req_valid), 128'(1));
        chk("hold_c0_addr", 128'(mem_req_addr), 128'(28'h0000010));
        chk("hold_c0_ic_ready", 128'(ic_req_ready), 128'(0));
        tick();
        dc_req_valid = 1; dc_req_addr = 28'h0000020;
        for (int k = 1; k < 3; k++) begin
            #1;
            chk("hold_addr", 128'(mem_req_addr), 128'(28'h0000010));
            chk("hold_dc_ready", 128'(dc_req_ready), 128'(0));
            tick();
        end
        mem_req_ready = 1;
        #1;
        chk("hold_fire_ic", 128'(ic_req_ready), 128'(1));
        chk("hold_fire_dc", 128'(dc_req_ready), 128'(0));
        chk("hold_fire_addr", 128'(mem_req_addr), 128'(28'h0000010));
        tick();
        clr();
        mem_resp_valid = 1; mem_resp_data = 128'h77;
        #1;
        chk("hold_resp_ic", 128'(ic_resp_valid), 128'(1));
        chk("hold_resp_dc", 128'(dc_resp_valid), 128'(0));
        tick();
        clr();

        // 4: dc write, data accepted two cycles after the command
        wd = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
        dc_req_valid = 1; dc_req_rw = 1; dc_req_addr = 28'h30;
        dc_req_data_valid = 1; dc_req_data_bits = wd; dc_req_data_mask = '1;
        ic_req_valid = 1; ic_req_addr = 28'h40;
        mem_req_data_ready = 0;
        #1;
        chk("wr_dc_ready", 128'(dc_req_ready), 128'(1));
        chk("wr_ic_ready", 128'(ic_req_ready), 128'(0));
        chk("wr_rw", 128'(mem_req_rw), 128'(1));
        chk("wr_dready0", 128'(dc_req_data_ready), 128'(0));
        tick();
        #1;
        chk("wd1_mem_valid", 128'(mem_req_valid), 128'(0));
        chk("wd1_dvalid", 128'(mem_req_data_valid), 128'(1));
        chk("wd1_ic_ready", 128'(ic_req_ready), 128'(0));
        chk("wd1_dc_ready", 128'(dc_req_ready), 128'(0));
        tick();
        mem_req_data_ready = 1;
        #1;
        chk("wd2_dready", 128'(dc_req_data_ready), 128'(1));
        chk("wd2_mem_valid", 128'(mem_req_valid), 128'(0));
        chk("wd2_bits", mem_req_data_bits, wd);
        chk("wd2_mask", 128'(mem_req_data_mask), 128'(16'hFFFF));
        chk("wd2_ic_ready", 128'(ic_req_ready), 128'(0));
        tick();
        dc_req_valid = 0; dc_req_data_valid = 0; dc_req_rw = 0;
        #1;
        chk("wd_after_ic", 128'(ic_req_ready), 128'(1));
        chk("wd_after_addr", 128'(mem_req_addr), 128'(28'h40));
        tick();
        clr();
        mem_resp_valid = 1;
        #1;
        chk("wd_resp_ic", 128'(ic_resp_valid), 128'(1));
        tick();
        clr();

        // 5: four reads outstanding fill the owner FIFO
        ic_req_valid = 1;
        for (int k = 0; k < 4; k++) begin
            ic_req_addr = 28'h50 + AB'(k);
            #1;
            chk("fill_ic_ready", 128'(ic_req_ready), 128'(1));
            tick();
        end
        dc_req_valid = 1; dc_req_rw = 1; dc_req_addr = 28'h60;
        dc_req_data_valid = 1; dc_req_data_bits = 128'h5;
        #1;
        chk("full_ic_blocked", 128'(ic_req_ready), 128'(0));
        chk("full_dc_ready", 128'(dc_req_ready), 128'(1));
        chk("full_dc_dready", 128'(dc_req_data_ready), 128'(1));
        chk("full_addr", 128'(mem_req_addr), 128'(28'h60));
        tick();
        dc_req_valid = 0; dc_req_rw = 0; dc_req_data_valid = 0;
        mem_resp_valid = 1;
        #1;
        chk("full_resp_ic", 128'(ic_resp_valid), 128'(1));
        chk("full_still_blk", 128'(ic_req_ready), 128'(0));
        tick();
        mem_resp_valid = 0;
        #1;
        chk("slot_freed", 128'(ic_req_ready), 128'(1));
        tick();
        ic_req_valid = 0;
        for (int k = 0; k < 4; k++) begin
            mem_resp_valid = 1;
            #1;
            chk("drain_ic", 128'(ic_resp_valid), 128'(1));
            chk("drain_dc", 128'(dc_resp_valid), 128'(0));
            tick();
        end
        clr();

        // 6: stray response sets a sticky error
        #1;
        chk("pre_err", 128'(err), 128'(0));
        mem_resp_valid = 1;
        #1;
        chk("stray_ic", 128'(ic_resp_valid), 128'(0));
        chk("stray_dc", 128'(dc_resp_valid), 128'(0));
        tick();
        mem_resp_valid = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("err_sticky", 128'(err), 128'(1));
            tick();
        end
        reset = 0;
        #1;
        chk("err_cleared", 128'(err), 128'(0));
        reset = 1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
